reorder_buffer: RTL
===================

// Module: reorder_buffer
// PURPOSE
//  In-order commit buffer between the out-of-order backend and the architectural regfile. Dispatch
//  allocates entries in program order; execution writeback marks them done with result data. Up to
//  RETIRE_WIDTH oldest done entries are presented each cycle as retire lanes that the regfile consumes
//  combinationally. A retiring mispredicted branch raises a flush and redirect and empties the buffer.
// PARAMETERS
//  ROB_DEPTH      16               entries; power of two, >= 4
//  DISPATCH_WIDTH 2                allocation lanes per cycle
//  RETIRE_WIDTH   AREG_WRITE_PORTS retire lanes; must equal the regfile write-port count
//  WB_PORTS       4                writeback ports
// PORTS
//  clk              in  1            clock, rising edge
//  reset            in  1            asynchronous, active-low reset
//  disp_valid       in  [DW]         dispatch lane valid; lanes are contiguous from lane 0
//  disp_dst         in  [DW][5]      architectural destination register
//  disp_regwrite    in  [DW]         instruction writes disp_dst
//  disp_pc          in  [DW][64]     instruction PC
//  disp_ready       out 1            all DW lanes can be accepted this cycle
//  disp_idx         out [DW][IW]     ROB index allocated to each lane; IW = log2(ROB_DEPTH)
//  wb_valid         in  [WB]         writeback valid
//  wb_idx           in  [WB][IW]     target entry
//  wb_data          in  [WB][64]     result value
//  wb_mispredict    in  [WB]         entry is a mispredicted control transfer
//  wb_target        in  [WB][64]     correct next PC; meaningful only with wb_mispredict
//  retire_valid     out [RW]         retire lane valid; lanes are contiguous from lane 0
//  retire_dst       out [RW][5]      destination register
//  retire_regwrite  out [RW]         write enable for the regfile
//  retire_data      out [RW][64]     value to commit
//  retire_pc        out [RW][64]     PC of the retiring instruction
//  flush            out 1            pipeline flush, asserted for one cycle
//  redirect_pc      out 64           fetch redirect target; valid only while flush = 1
// BEHAVIOUR
//  - Storage is a circular buffer. head and tail are IW+1 bits wide; the extra bit is a wrap bit.
//    count = tail - head. Buffer is full when count = ROB_DEPTH and empty when head = tail.
//  - Reset (reset = 0): head = tail = 0 and all entry valid/done bits = 0. While in reset, every output
//    is 0 except disp_ready, which is 1.
//  - Dispatch is all-or-nothing. disp_ready = (ROB_DEPTH - count >= DW) && !flush. It is computed from
//    registered count only; same-cycle retires are not credited.
//  - When disp_ready is 1, lane k of disp_idx = tail + k (mod depth). Each valid lane writes its entry
//    with valid = 1 and done = 0. tail advances by popcount(disp_valid). Lanes with disp_valid = 1 while
//    disp_ready = 0 are dropped; upstream holds them.
//  - Writeback sets done, data, mispredict and target on the targeted entry at the next edge.
//    A writeback to an entry with valid = 0 is ignored. If two ports hit the same index in one cycle,
//    the highest port number wins.
//  - Retire lanes are combinational from registered state only; there is no writeback bypass.
//    A writeback in cycle t can retire in cycle t+1 at the earliest.
//  - Lane j is valid iff entry head+j has valid = 1 and done = 1, every lane i < j is valid, and no lane
//    i < j is a mispredict. The first retiring mispredict entry is the last valid lane.
//    head advances by the number of valid retire lanes; retired entries clear valid.
//  - Flush: when a valid retire lane carries mispredict, flush = 1 and redirect_pc = that entry's target
//    in the same cycle. That entry and all older lanes still retire. At the next edge head = tail = 0,
//    all valid bits clear, and same-cycle dispatch and writeback are discarded.
//  - Wrap-around: indices are taken modulo ROB_DEPTH. The wrap bit distinguishes full from empty.
//    Retire and dispatch windows may straddle entry ROB_DEPTH-1 to entry 0.
//  - Simultaneous dispatch, writeback and retire in one cycle are all legal and independent,
//    except during flush.
//  - Reset asserted mid-operation returns the block to the reset state immediately (asynchronous).
//    In-flight entries are lost.
// STRUCTURE
//  - Package common gains: rob_idx_t (IW+1 bits including wrap), rob_entry_t (valid, done, mispredict,
//    regwrite, dst, pc, data, target), ROB_DEPTH and DISPATCH_WIDTH.
//  - One sub-module, rob_retire_sel: combinational. Inputs are the RW entries at head..head+RW-1.
//    Outputs are retire lane valids, the retire count, flush and the redirect select.
//  - Entry array is flops, not RAM, because of multi-port writeback plus RW-wide head reads.
// TESTING
//  1. Reset, then dispatch 2 lanes per cycle for 8 cycles with no writeback -> disp_idx 0..15,
//     count = 16, disp_ready = 0, no retire.
//  2. From test 1, write back idx 1, then idx 0 one cycle later -> no retire until idx 0 is done.
//     The next cycle retires lanes 0 and 1 in order with correct dst and data.
//  3. Regwrite = 0 entry at head, done -> retire_valid = 1 and retire_regwrite = 0;
//     the regfile must be unchanged.
//  4. Entries 3..5 done, entry 4 has mispredict with target 0x8000_0100 -> retire 3 and 4 with flush = 1
//     and redirect_pc = 0x8000_0100. Entry 5 is not retired; the next cycle shows count = 0 and
//     disp_idx = 0.
//  5. Run 40 dispatch/writeback/retire cycles so head wraps twice -> retire order matches dispatch order
//     across the 15-to-0 boundary. Full and empty flags are correct at equal head/tail indices.
//  6. Assert reset mid-stream with count = 7 -> outputs clear asynchronously. After release, the first
//     dispatch gets idx 0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// ---------------------------------------------------------------------------
// reorder_buffer_pkg
// Shared sizing constants and types for the reorder buffer and its retire
// selector.
//   rob_idx_t   : head/tail pointer, ROB_IW index bits plus one wrap bit
//   rob_slot_t  : plain entry index (pointer without the wrap bit)
//   rob_entry_t : one buffer entry (status bits, destination, pc, result, target)
// ---------------------------------------------------------------------------
package reorder_buffer_pkg;

  localparam int ROB_DEPTH        = 16;
  localparam int DISPATCH_WIDTH   = 2;
  localparam int AREG_WRITE_PORTS = 2;
  localparam int RETIRE_WIDTH     = AREG_WRITE_PORTS;
  localparam int WB_PORTS         = 4;

  localparam int ROB_IW     = $clog2(ROB_DEPTH);
  localparam int RET_CNT_W  = $clog2(RETIRE_WIDTH + 1);
  localparam int RET_SEL_W  = (RETIRE_WIDTH > 1) ? $clog2(RETIRE_WIDTH) : 1;
  localparam int DISP_CNT_W = $clog2(DISPATCH_WIDTH + 1);

  typedef logic [ROB_IW:0]   rob_idx_t;
  typedef logic [ROB_IW-1:0] rob_slot_t;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        mispredict;
    logic        regwrite;
    logic [4:0]  dst;
    logic [63:0] pc;
    logic [63:0] data;
    logic [63:0] target;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_retire_sel.sv
// ---------------------------------------------------------------------------
// rob_retire_sel
// Combinational retire-lane selector. Looks at the status bits of the
// RETIRE_WIDTH entries starting at head (lane 0 = oldest).
//   win_valid/win_done/win_mispredict : status of entries head..head+RW-1
//   lane_valid   : contiguous retire lanes from lane 0
//   retire_cnt   : number of valid lanes (head advance)
//   flush        : a retiring lane is a mispredicted branch
//   redirect_sel : lane whose target is the redirect PC (valid with flush)
// ---------------------------------------------------------------------------
module rob_retire_sel
  import reorder_buffer_pkg::*;
(
  input  logic [RETIRE_WIDTH-1:0] win_valid,
  input  logic [RETIRE_WIDTH-1:0] win_done,
  input  logic [RETIRE_WIDTH-1:0] win_mispredict,
  output logic [RETIRE_WIDTH-1:0] lane_valid,
  output logic [RET_CNT_W-1:0]    retire_cnt,
  output logic                    flush,
  output logic [RET_SEL_W-1:0]    redirect_sel
);

  always_comb begin : sel_logic
    // chain_open drops as soon as a lane cannot retire or a mispredict retires,
    // so no younger lane may follow it.
    logic chain_open;
    lane_valid   = '0;
    retire_cnt   = '0;
    flush        = 1'b0;
    redirect_sel = '0;
    chain_open   = 1'b1;
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      if (chain_open && win_valid[j] && win_done[j]) begin
        lane_valid[j] = 1'b1;
        retire_cnt    = retire_cnt + RET_CNT_W'(1);
        if (win_mispredict[j]) begin
          flush        = 1'b1;
          redirect_sel = RET_SEL_W'(j);
          chain_open   = 1'b0;
        end
      end else begin
        chain_open = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
// In-order commit buffer. Dispatch allocates entries at tail in program
// order, writeback marks them done, up to RETIRE_WIDTH oldest done entries
// are presented combinationally as retire lanes. A retiring mispredict
// raises flush/redirect_pc and empties the buffer at the next edge.
// Ports:
//   clk, reset (async, active low)
//   disp_valid/dst/regwrite/pc -> disp_ready, disp_idx  : allocation
//   wb_valid/idx/data/mispredict/target                 : writeback
//   retire_valid/dst/regwrite/data/pc                   : commit lanes
//   flush, redirect_pc                                  : branch recovery
// ---------------------------------------------------------------------------
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [DISPATCH_WIDTH-1:0]                 disp_valid,
  input  logic [DISPATCH_WIDTH-1:0][4:0]            disp_dst,
  input  logic [DISPATCH_WIDTH-1:0]                 disp_regwrite,
  input  logic [DISPATCH_WIDTH-1:0][63:0]           disp_pc,
  output logic                                      disp_ready,
  output logic [DISPATCH_WIDTH-1:0][ROB_IW-1:0]     disp_idx,
  input  logic [WB_PORTS-1:0]                       wb_valid,
  input  logic [WB_PORTS-1:0][ROB_IW-1:0]           wb_idx,
  input  logic [WB_PORTS-1:0][63:0]                 wb_data,
  input  logic [WB_PORTS-1:0]                       wb_mispredict,
  input  logic [WB_PORTS-1:0][63:0]                 wb_target,
  output logic [RETIRE_WIDTH-1:0]                   retire_valid,
  output logic [RETIRE_WIDTH-1:0][4:0]              retire_dst,
  output logic [RETIRE_WIDTH-1:0]                   retire_regwrite,
  output logic [RETIRE_WIDTH-1:0][63:0]             retire_data,
  output logic [RETIRE_WIDTH-1:0][63:0]             retire_pc,
  output logic                                      flush,
  output logic [63:0]                               redirect_pc
);

  // Flops rather than RAM: several writeback ports plus a multi-entry head read.
  rob_entry_t                  entries_reg [ROB_DEPTH];
  rob_idx_t                    head_reg;
  rob_idx_t                    tail_reg;
  rob_idx_t                    count;
  rob_entry_t [RETIRE_WIDTH-1:0] window;
  logic [RETIRE_WIDTH-1:0]     win_valid;
  logic [RETIRE_WIDTH-1:0]     win_done;
  logic [RETIRE_WIDTH-1:0]     win_mispredict;
  logic [RETIRE_WIDTH-1:0]     lane_valid;
  logic [RET_CNT_W-1:0]        retire_cnt;
  logic [RET_SEL_W-1:0]        redirect_sel;
  logic [DISP_CNT_W-1:0]       disp_cnt;

  // Wrap bit makes tail - head equal ROB_DEPTH when full, 0 when empty.
  assign count      = tail_reg - head_reg;
  assign disp_ready = ((rob_idx_t'(ROB_DEPTH) - count) >= rob_idx_t'(DISPATCH_WIDTH)) && !flush;

  generate
    for (genvar gi = 0; gi < RETIRE_WIDTH; gi++) begin : g_retire
      assign window[gi]         = entries_reg[head_reg[ROB_IW-1:0] + rob_slot_t'(gi)];
      assign win_valid[gi]      = window[gi].valid;
      assign win_done[gi]       = window[gi].done;
      assign win_mispredict[gi] = window[gi].mispredict;
      // Payload is gated so idle lanes present zeros to the regfile.
      assign retire_valid[gi]    = lane_valid[gi];
      assign retire_dst[gi]      = lane_valid[gi] ? window[gi].dst      : '0;
      assign retire_regwrite[gi] = lane_valid[gi] && window[gi].regwrite;
      assign retire_data[gi]     = lane_valid[gi] ? window[gi].data     : '0;
      assign retire_pc[gi]       = lane_valid[gi] ? window[gi].pc       : '0;
    end
    for (genvar gi = 0; gi < DISPATCH_WIDTH; gi++) begin : g_disp_idx
      // Forced to zero while reset is held so every output reads 0 in reset.
      assign disp_idx[gi] = reset ? (tail_reg[ROB_IW-1:0] + rob_slot_t'(gi)) : '0;
    end
  endgenerate

  rob_retire_sel u_retire_sel (
    .win_valid      (win_valid),
    .win_done       (win_done),
    .win_mispredict (win_mispredict),
    .lane_valid     (lane_valid),
    .retire_cnt     (retire_cnt),
    .flush          (flush),
    .redirect_sel   (redirect_sel)
  );

  assign redirect_pc = flush ? window[redirect_sel].target : '0;

  // Lanes are contiguous, so the valid count is also the tail advance.
  always_comb begin
    disp_cnt = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      disp_cnt = disp_cnt + DISP_CNT_W'(disp_valid[k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg <= '0;
      tail_reg <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_reg[i] <= '0;
      end
    end else if (flush) begin
      // Retiring lanes commit this cycle; everything younger is squashed,
      // including any dispatch or writeback presented alongside the flush.
      head_reg <= '0;
      tail_reg <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_reg[i].valid <= 1'b0;
        entries_reg[i].done  <= 1'b0;
      end
    end else begin
      for (int j = 0; j < RETIRE_WIDTH; j++) begin
        if (lane_valid[j]) begin
          entries_reg[head_reg[ROB_IW-1:0] + rob_slot_t'(j)].valid <= 1'b0;
        end
      end
      head_reg <= head_reg + rob_idx_t'(retire_cnt);

      // Ascending port order: the highest-numbered port's NBA lands last.
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && entries_reg[wb_idx[p]].valid) begin
          entries_reg[wb_idx[p]].done       <= 1'b1;
          entries_reg[wb_idx[p]].data       <= wb_data[p];
          entries_reg[wb_idx[p]].mispredict <= wb_mispredict[p];
          entries_reg[wb_idx[p]].target     <= wb_target[p];
        end
      end

      if (disp_ready) begin
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
          if (disp_valid[k]) begin
            entries_reg[tail_reg[ROB_IW-1:0] + rob_slot_t'(k)] <= '{
              valid:      1'b1,
              done:       1'b0,
              mispredict: 1'b0,
              regwrite:   disp_regwrite[k],
              dst:        disp_dst[k],
              pc:         disp_pc[k],
              data:       64'd0,
              target:     64'd0
            };
          end
        end
        tail_reg <= tail_reg + rob_idx_t'(disp_cnt);
      end
    end
  end

endmodule
